load_access_unit: RTL

Memory-read side of the shared data bus whose write side is the commit stage's store path. Accepts one load at a time from the load queue, waits out older stores, arbitrates for the data bus against commit-time stores, performs a fixed-latency byte-addressed read, then sign- or zero-extends the result. The result is broadcast on the CDB tagged with the load's RoB index.

---
 rtl/load_access_unit_if.sv | 28 ++
 rtl/load_access_unit.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/load_access_unit_if.sv
// Load-request and CDB-broadcast handshake bundle for load_access_unit.
interface load_access_unit_if #(
    parameter int unsigned TAG_W = 7
);
    logic             ld_valid;
    logic             ld_ready;
    logic [TAG_W-1:0] ld_tag;
    logic [31:0]      ld_addr;
    logic [2:0]       ld_funct3;
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [31:0]      cdb_value;
    logic             cdb_ack;

    modport master (
        output ld_valid, ld_tag, ld_addr, ld_funct3,
        input  ld_ready,
        input  cdb_valid, cdb_tag, cdb_value,
        output cdb_ack
    );

    modport slave (
        input  ld_valid, ld_tag, ld_addr, ld_funct3,
        output ld_ready,
        output cdb_valid, cdb_tag, cdb_value,
        input  cdb_ack
    );
endinterface

// File: rtl/load_access_unit.sv
// Single-outstanding load unit: waits out older stores, arbitrates the data bus, extends and broadcasts.
// Optional store-to-load forwarding enabled by defining LOAD_STORE_FWD_EN.
module load_access_unit #(
    parameter int unsigned LAT   = 4,
    parameter int unsigned TAG_W = 7
) (
    input  logic                clock,
    input  logic                reset,
    load_access_unit_if.slave   ld_cdb,
    input  logic                older_store_pending,
    input  logic                fwd_valid,
    input  logic [31:0]         fwd_addr,
    input  logic [1:0]          fwd_size,
    input  logic [31:0]         fwd_data,
    input  logic                store_req,
    input  logic                store_busy,
    output logic                load_busy,
    output logic [31:0]         mem_addr,
    input  logic [31:0]         mem_rdata,
    input  logic                flush
);
    localparam int unsigned CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT_BUS, S_ACCESS, S_RESP} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [31:0]        addr_q, addr_d;
    logic [2:0]         funct3_q, funct3_d;
    logic               ld_ready_q, ld_ready_d;
    logic               load_busy_q, load_busy_d;
    logic [31:0]        mem_addr_q, mem_addr_d;
    logic               cdb_valid_q, cdb_valid_d;
    logic [TAG_W-1:0]   cdb_tag_q, cdb_tag_d;
    logic [31:0]        cdb_value_q, cdb_value_d;

    // Unsupported funct3 encodings fall through to the full-word case.
    function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] r;
        case (f3)
            3'b000:  r = {{24{d[7]}}, d[7:0]};
            3'b001:  r = {{16{d[15]}}, d[15:0]};
            3'b100:  r = {24'd0, d[7:0]};
            3'b101:  r = {16'd0, d[15:0]};
            default: r = d;
        endcase
        return r;
    endfunction

`ifdef LOAD_STORE_FWD_EN
    function automatic logic [1:0] load_size(input logic [2:0] f3);
        logic [1:0] s;
        case (f3)
            3'b000, 3'b100: s = 2'd0;
            3'b001, 3'b101: s = 2'd1;
            default:        s = 2'd2;
        endcase
        return s;
    endfunction

    logic fwd_hit_c;
    assign fwd_hit_c = fwd_valid && (fwd_addr == addr_q) && (fwd_size >= load_size(funct3_q));
`else
    logic unused_fwd;
    assign unused_fwd = ^{fwd_valid, fwd_addr, fwd_size, fwd_data};
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tag_d       = tag_q;
        addr_d      = addr_q;
        funct3_d    = funct3_q;
        ld_ready_d  = ld_ready_q;
        load_busy_d = load_busy_q;
        mem_addr_d  = mem_addr_q;
        cdb_valid_d = cdb_valid_q;
        cdb_tag_d   = cdb_tag_q;
        cdb_value_d = cdb_value_q;

        if (flush) begin
            // Squash: drop whatever is in flight without broadcasting.
            state_d     = S_IDLE;
            ld_ready_d  = 1'b1;
            load_busy_d = 1'b0;
            cdb_valid_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ld_cdb.ld_valid && ld_ready_q) begin
                        tag_d      = ld_cdb.ld_tag;
                        addr_d     = ld_cdb.ld_addr;
                        funct3_d   = ld_cdb.ld_funct3;
                        ld_ready_d = 1'b0;
                        state_d    = S_WAIT_BUS;
                    end
                end
                S_WAIT_BUS: begin
`ifdef LOAD_STORE_FWD_EN
                    if (fwd_hit_c) begin
                        cdb_valid_d = 1'b1;
                        cdb_tag_d   = tag_q;
                        cdb_value_d = extend(funct3_q, fwd_data);
                        state_d     = S_RESP;
                    end else
`endif
                    // A commit-time store wins any simultaneous bus request.
                    if (!older_store_pending && !store_req && !store_busy) begin
                        load_busy_d = 1'b1;
                        mem_addr_d  = addr_q;
                        cnt_d       = CNT_W'(LAT - 1);
                        state_d     = S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (cnt_q == '0) begin
                        load_busy_d = 1'b0;
                        cdb_valid_d = 1'b1;
                        cdb_tag_d   = tag_q;
                        cdb_value_d = extend(funct3_q, mem_rdata);
                        state_d     = S_RESP;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                S_RESP: begin
                    if (ld_cdb.cdb_ack) begin
                        cdb_valid_d = 1'b0;
                        ld_ready_d  = 1'b1;
                        state_d     = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            tag_q       <= '0;
            addr_q      <= '0;
            funct3_q    <= '0;
            ld_ready_q  <= 1'b1;
            load_busy_q <= 1'b0;
            mem_addr_q  <= '0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_value_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tag_q       <= tag_d;
            addr_q      <= addr_d;
            funct3_q    <= funct3_d;
            ld_ready_q  <= ld_ready_d;
            load_busy_q <= load_busy_d;
            mem_addr_q  <= mem_addr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_value_q <= cdb_value_d;
        end
    end

    assign ld_cdb.ld_ready  = ld_ready_q;
    assign ld_cdb.cdb_valid = cdb_valid_q;
    assign ld_cdb.cdb_tag   = cdb_tag_q;
    assign ld_cdb.cdb_value = cdb_value_q;
    assign load_busy        = load_busy_q;
    assign mem_addr         = mem_addr_q;
endmodule
